fft_frame_ctrl: RTL and testbench
=================================

// Module: fft_frame_ctrl
// PURPOSE
//   Frame sequencer in front of fft_top; runs the whole frame: load ADC samples -> FFT -> read out results.
//   - Loads one 2048-sample frame into the four 512-word input banks through the per-bank write ports.
//   - Pulses start, waits for RDY, then sweeps all four read ports and streams the results out.
//   - Sits between the ADC front-end and fft_top; owns every FFT control and address input.
// PARAMETERS
//   DW        16     ADC sample / result word width (signed)
//   AW        9      bank address width
//   DEPTH     512    words per bank; frame length = 4*DEPTH
//   RD_LAT    2      fft_top read latency: address to oDATA_RE_x valid, in cycles
//   RDY_BLANK 2      cycles after oSTART during which iFFT_RDY is ignored
//   TIMEOUT   65535  max cycles in WAIT_RDY before error
// PORTS
//   iCLK         in   1      clock, sole clock domain
//   iRESET       in   1      synchronous, active-high reset
//   iENABLE      in   1      level; permits a new frame to start from IDLE
//   iADC_VALID   in   1      ADC sample strobe, 1 cycle per sample
//   iADC_DATA    in   DW     signed ADC sample
//   iFFT_RDY     in   1      fft_top oRDY
//   iFFT_RE      in   4*DW   {oDATA_RE_3..oDATA_RE_0} from fft_top
//   oFFT_DATA    out  DW     to fft_top iDATA; registered copy of iADC_DATA
//   oADDR_WR     out  AW     shared write address, drives iADDR_WR_0..3
//   oWE          out  4      one-hot write enables, drive iWE_0..3
//   oSTART       out  1      fft_top iSTART, 1-cycle pulse
//   oADDR_RD     out  AW     shared read address, drives iADDR_RD_0..3
//   oOUT_VALID   out  1      oOUT_DATA valid
//   oOUT_DATA    out  4*DW   registered copy of iFFT_RE
//   oOUT_ADDR    out  AW     bin address of oOUT_DATA
//   oBUSY        out  1      high in every state except IDLE
//   oFRAME_DONE  out  1      1-cycle pulse when the last result word has been output
//   oOVERRUN     out  1      sticky: iADC_VALID seen outside LOAD; cleared only by reset
//   oERR         out  1      sticky: RDY timeout occurred; cleared only by reset or next oSTART
// BEHAVIOUR
//   Reset: every output = 0, state = IDLE, counters = 0.
//   States:
//   - IDLE: -> LOAD when iENABLE=1.
//   - LOAD: each iADC_VALID writes one sample at the next slot (bank, addr).
//     * Sample n -> bank n/DEPTH, address n%DEPTH, order bank0 0..511, bank1, ..., bank3 511.
//     * Write is registered: oWE[bank]=1, oADDR_WR and oFFT_DATA are driven the cycle after iADC_VALID; oWE is one-hot or zero.
//     * The 2048th sample's write cycle -> START. iENABLE falling mid-LOAD is ignored; the frame completes.
//   - START: oWE=0, oSTART=1 for exactly 1 cycle, clears oERR -> WAIT_RDY.
//   - WAIT_RDY: iFFT_RDY is ignored for the first RDY_BLANK cycles.
//     * iFFT_RDY=1 after the blank -> READ.
//     * TIMEOUT cycles without RDY -> oERR=1, -> IDLE.
//   - READ: oADDR_RD counts 0..DEPTH-1, one per cycle, no gaps.
//     * oOUT_VALID, oOUT_DATA and oOUT_ADDR follow RD_LAT+1 cycles after the address (RAM latency plus output register).
//     * After the last address the pipeline drains.
//     * oFRAME_DONE pulses together with the last oOUT_VALID -> IDLE.
//   - Back-to-back frames: if iENABLE=1 in IDLE, the next LOAD starts on the cycle after oFRAME_DONE.
//   Counters and wrap: the sample counter is AW+2 bits and wraps to 0 on entering START; the read counter is AW bits.
//   Overrun: iADC_VALID in any state other than LOAD is dropped and sets oOVERRUN; the data is never written.
//   Reset mid-operation: the state machine aborts, the partial frame is discarded, oSTART/oWE go to 0 the next cycle.
// TESTING
//   1. Reset, then iENABLE=1 and 2048 consecutive iADC_VALID -> oWE[0] on addr 0..511, then oWE[1] through oWE[3]; oSTART exactly once, 1 cycle after the last write.
//   2. iFFT_RDY held high during the blank window -> no READ until RDY_BLANK cycles have elapsed after oSTART.
//   3. iFFT_RDY=1 -> oADDR_RD 0..511 contiguous; oOUT_VALID for 512 cycles, starting 3 cycles after the first address; oOUT_ADDR matches; oFRAME_DONE on the last valid.
//   4. iADC_VALID pulsed during WAIT_RDY -> oOVERRUN=1 and no oWE; oOVERRUN stays 1 through the next frame.
//   5. iFFT_RDY held 0 -> oERR=1 after 65535 WAIT_RDY cycles, state returns to IDLE; the next frame's oSTART clears oERR.
//   6. iRESET asserted at sample 1000 of LOAD -> all outputs 0 next cycle; a new frame then restarts at bank0 addr 0.

Source files
------------

// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: ADC input, fft_top control/data and result stream of the frame sequencer
interface fft_frame_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 9
);
    logic            iENABLE;
    logic            iADC_VALID;
    logic [DW-1:0]   iADC_DATA;
    logic            iFFT_RDY;
    logic [4*DW-1:0] iFFT_RE;
    logic [DW-1:0]   oFFT_DATA;
    logic [AW-1:0]   oADDR_WR;
    logic [3:0]      oWE;
    logic            oSTART;
    logic [AW-1:0]   oADDR_RD;
    logic            oOUT_VALID;
    logic [4*DW-1:0] oOUT_DATA;
    logic [AW-1:0]   oOUT_ADDR;
    logic            oBUSY;
    logic            oFRAME_DONE;
    logic            oOVERRUN;
    logic            oERR;
    modport master (
        output iENABLE, iADC_VALID, iADC_DATA, iFFT_RDY, iFFT_RE,
        input  oFFT_DATA, oADDR_WR, oWE, oSTART, oADDR_RD, oOUT_VALID, oOUT_DATA,
               oOUT_ADDR, oBUSY, oFRAME_DONE, oOVERRUN, oERR
    );
    modport slave (
        input  iENABLE, iADC_VALID, iADC_DATA, iFFT_RDY, iFFT_RE,
        output oFFT_DATA, oADDR_WR, oWE, oSTART, oADDR_RD, oOUT_VALID, oOUT_DATA,
               oOUT_ADDR, oBUSY, oFRAME_DONE, oOVERRUN, oERR
    );
endinterface

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: loads one 4-bank ADC frame into fft_top, starts it, waits for RDY and streams the results out
module fft_frame_ctrl #(
    parameter int DW        = 16,
    parameter int AW        = 9,
    parameter int DEPTH     = 512,
    parameter int RD_LAT    = 2,
    parameter int RDY_BLANK = 2,
    parameter int TIMEOUT   = 65535
) (
    input logic             iCLK,
    input logic             iRESET,
    fft_frame_ctrl_if.slave bus
);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_RDY, READ, DRAIN} state_t;
    state_t                    state_q, state_d;
    logic [AW+1:0]             smp_cnt_q, smp_cnt_d;
    logic [WW-1:0]             wait_cnt_q, wait_cnt_d;
    logic [AW-1:0]             rd_cnt_q, rd_cnt_d;
    logic [AW-1:0]             addr_wr_q, addr_wr_d;
    logic [AW-1:0]             out_addr_q, out_addr_d;
    logic [RD_LAT-1:0]         vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0][AW-1:0] addr_pipe_q, addr_pipe_d;
    logic [DW-1:0]             fft_data_q, fft_data_d;
    logic [4*DW-1:0]           out_data_q, out_data_d;
    logic [3:0]                we_q, we_d;
    logic                      start_q, start_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      ovr_q, ovr_d;
    logic                      err_q, err_d;
    logic                      last_out;
    // the pipeline tail carries the address whose data fft_top presents this cycle
    assign last_out = vld_pipe_q[RD_LAT-1] && addr_pipe_q[RD_LAT-1] == AW'(DEPTH - 1);
    always_comb begin
        state_d        = state_q;
        smp_cnt_d      = smp_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        rd_cnt_d       = rd_cnt_q;
        addr_wr_d      = addr_wr_q;
        fft_data_d     = fft_data_q;
        we_d           = '0;
        start_d        = 1'b0;
        err_d          = err_q;
        ovr_d          = ovr_q | (bus.iADC_VALID && state_q != LOAD);
        vld_pipe_d[0]  = state_q == READ;
        addr_pipe_d[0] = rd_cnt_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            addr_pipe_d[i] = addr_pipe_q[i-1];
        end
        out_valid_d = vld_pipe_q[RD_LAT-1];
        out_addr_d  = out_valid_d ? addr_pipe_q[RD_LAT-1] : out_addr_q;
        out_data_d  = out_valid_d ? bus.iFFT_RE : out_data_q;
        done_d      = last_out;
        case (state_q)
            IDLE: if (bus.iENABLE) state_d = LOAD;
            LOAD: if (bus.iADC_VALID) begin
                we_d       = 4'b0001 << smp_cnt_q[AW+1:AW];
                addr_wr_d  = smp_cnt_q[AW-1:0];
                fft_data_d = bus.iADC_DATA;
                smp_cnt_d  = smp_cnt_q + (AW+2)'(1);
                if (smp_cnt_q == (AW+2)'(4 * DEPTH - 1)) state_d = START;
            end
            START: begin
                start_d    = 1'b1;
                err_d      = 1'b0;
                wait_cnt_d = '0;
                state_d    = WAIT_RDY;
            end
            WAIT_RDY: begin
                wait_cnt_d = wait_cnt_q + WW'(1);
                if (bus.iFFT_RDY && wait_cnt_q >= WW'(RDY_BLANK)) state_d = READ;
                else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            READ: begin
                rd_cnt_d = rd_cnt_q + AW'(1);
                if (rd_cnt_q == AW'(DEPTH - 1)) state_d = DRAIN;
            end
            DRAIN: if (last_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q     <= IDLE;
            smp_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            addr_wr_q   <= '0;
            out_addr_q  <= '0;
            vld_pipe_q  <= '0;
            addr_pipe_q <= '0;
            fft_data_q  <= '0;
            out_data_q  <= '0;
            we_q        <= '0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            smp_cnt_q   <= smp_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            addr_wr_q   <= addr_wr_d;
            out_addr_q  <= out_addr_d;
            vld_pipe_q  <= vld_pipe_d;
            addr_pipe_q <= addr_pipe_d;
            fft_data_q  <= fft_data_d;
            out_data_q  <= out_data_d;
            we_q        <= we_d;
            start_q     <= start_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovr_q       <= ovr_d;
            err_q       <= err_d;
        end
    end
    assign bus.oFFT_DATA   = fft_data_q;
    assign bus.oADDR_WR    = addr_wr_q;
    assign bus.oWE         = we_q;
    assign bus.oSTART      = start_q;
    assign bus.oADDR_RD    = rd_cnt_q;
    assign bus.oOUT_VALID  = out_valid_q;
    assign bus.oOUT_DATA   = out_data_q;
    assign bus.oOUT_ADDR   = out_addr_q;
    assign bus.oBUSY       = busy_q;
    assign bus.oFRAME_DONE = done_q;
    assign bus.oOVERRUN    = ovr_q;
    assign bus.oERR        = err_q;
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: randomized frames checked against a sample-list model, with an identity fft_top RAM stand-in
module tb_fft_frame_ctrl;
    localparam int DEPTH = 512;
    localparam int FRAME = 4 * DEPTH;
    typedef struct {
        int pct;
        int rdy_delay;
        bit ovr;
        int lat;
    } vec_t;
    logic        iCLK   = 1'b0;
    logic        iRESET = 1'b1;
    int          checks = 0;
    int          errors = 0;
    bit          ovr_exp = 1'b0;
    bit          err_exp = 1'b0;
    logic [15:0] frame [$];
    logic [15:0] mem [4][DEPTH];
    logic [63:0] rp1, rp2;
    vec_t        tbl [3];

    fft_frame_ctrl_if #(.DW(16), .AW(9)) bus ();
    fft_frame_ctrl dut (.iCLK(iCLK), .iRESET(iRESET), .bus(bus));

    always #5 iCLK = ~iCLK;

    // fft_top stand-in: four banks, results equal the stored samples, two-cycle read latency
    always @(posedge iCLK) begin
        for (int b = 0; b < 4; b++)
            if (bus.oWE[b]) mem[b][bus.oADDR_WR] <= bus.oFFT_DATA;
        rp1 <= {mem[3][bus.oADDR_RD], mem[2][bus.oADDR_RD], mem[1][bus.oADDR_RD], mem[0][bus.oADDR_RD]};
        rp2 <= rp1;
    end
    assign bus.iFFT_RE = rp2;

    task automatic tick();
        @(negedge iCLK);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"},        64'(bus.oWE),         64'(0));
        chk({tag, "_addr_wr"},   64'(bus.oADDR_WR),    64'(0));
        chk({tag, "_fft_data"},  64'(bus.oFFT_DATA),   64'(0));
        chk({tag, "_start"},     64'(bus.oSTART),      64'(0));
        chk({tag, "_addr_rd"},   64'(bus.oADDR_RD),    64'(0));
        chk({tag, "_out_valid"}, 64'(bus.oOUT_VALID),  64'(0));
        chk({tag, "_out_data"},  bus.oOUT_DATA,        64'(0));
        chk({tag, "_out_addr"},  64'(bus.oOUT_ADDR),   64'(0));
        chk({tag, "_busy"},      64'(bus.oBUSY),       64'(0));
        chk({tag, "_done"},      64'(bus.oFRAME_DONE), 64'(0));
        chk({tag, "_overrun"},   64'(bus.oOVERRUN),    64'(0));
        chk({tag, "_err"},       64'(bus.oERR),        64'(0));
    endtask

    task automatic wr_check(input bit v, input int n, input logic [15:0] d);
        chk("we", 64'(bus.oWE), v ? (64'(1) << (n / DEPTH)) : 64'(0));
        if (v) begin
            chk("addr_wr", 64'(bus.oADDR_WR), 64'(n % DEPTH));
            chk("wr_data", 64'(bus.oFFT_DATA), 64'(d));
        end
    endtask

    // called from IDLE; returns on the oSTART cycle for a full frame, else on the last write cycle
    task automatic load_frame(input int pct, input int cnt);
        int          n  = 0;
        int          pn = 0;
        bit          pv = 1'b0;
        logic [15:0] pd = '0;
        frame.delete();
        bus.iENABLE = 1'b1;
        tick();
        chk("busy_load", 64'(bus.oBUSY), 64'(1));
        chk("out_valid_load", 64'(bus.oOUT_VALID), 64'(0));
        while (n < cnt) begin
            wr_check(pv, pn, pd);
            chk("ovr_load", 64'(bus.oOVERRUN), 64'(ovr_exp));
            chk("err_load", 64'(bus.oERR), 64'(err_exp));
            pv = $urandom_range(99) < pct;
            pd = 16'($urandom);
            pn = n;
            bus.iADC_VALID = pv;
            bus.iADC_DATA  = pd;
            if (pv) begin
                frame.push_back(pd);
                n++;
            end
            if (n == 1) bus.iENABLE = 1'b0;
            tick();
        end
        wr_check(pv, pn, pd);
        bus.iADC_VALID = 1'b0;
        if (cnt == FRAME) begin
            chk("start_early", 64'(bus.oSTART), 64'(0));
            tick();
            err_exp = 1'b0;
            chk("start_pulse", 64'(bus.oSTART), 64'(1));
            chk("we_start", 64'(bus.oWE), 64'(0));
            chk("err_at_start", 64'(bus.oERR), 64'(err_exp));
        end
    endtask

    // called on the oSTART cycle; returns on the oFRAME_DONE cycle
    task automatic read_frame(input int d, input bit ovr, input int lat);
        int off = 0;
        while (!bus.oOUT_VALID && off < 64) begin
            chk("ovr_wait", 64'(bus.oOVERRUN), 64'(ovr_exp));
            chk("we_wait", 64'(bus.oWE), 64'(0));
            if (off > 0) chk("start_once", 64'(bus.oSTART), 64'(0));
            bus.iFFT_RDY   = off >= d;
            bus.iADC_VALID = ovr && off == 1;
            if (ovr && off == 1) ovr_exp = 1'b1;
            tick();
            off++;
        end
        bus.iFFT_RDY   = 1'b0;
        bus.iADC_VALID = 1'b0;
        chk("first_valid_lat", 64'(off), 64'(lat));
        for (int a = 0; a < DEPTH; a++) begin
            chk("out_valid", 64'(bus.oOUT_VALID), 64'(1));
            chk("out_addr", 64'(bus.oOUT_ADDR), 64'(a));
            chk("out_data", bus.oOUT_DATA, {frame[3*DEPTH+a], frame[2*DEPTH+a], frame[DEPTH+a], frame[a]});
            chk("frame_done", 64'(bus.oFRAME_DONE), 64'(a == DEPTH - 1));
            chk("busy_read", 64'(bus.oBUSY), 64'(a != DEPTH - 1));
            chk("ovr_read", 64'(bus.oOVERRUN), 64'(ovr_exp));
            if (a + 3 < DEPTH) chk("addr_rd", 64'(bus.oADDR_RD), 64'(a + 3));
            if (a < DEPTH - 1) tick();
        end
    endtask

    task automatic wait_timeout();
        int off = 0;
        while (!bus.oERR && off < 70000) begin
            tick();
            off++;
        end
        err_exp = 1'b1;
        chk("timeout_lat", 64'(off), 64'(65535));
        chk("busy_timeout", 64'(bus.oBUSY), 64'(0));
        chk("out_valid_timeout", 64'(bus.oOUT_VALID), 64'(0));
    endtask

    initial begin
        tbl[0] = '{100, 0, 1'b0, 6};
        tbl[1] = '{80,  4, 1'b1, 8};
        tbl[2] = '{65,  7, 1'b0, 11};
        bus.iENABLE    = 1'b0;
        bus.iADC_VALID = 1'b0;
        bus.iADC_DATA  = '0;
        bus.iFFT_RDY   = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        iRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_frame(tbl[i].pct, FRAME);
            read_frame(tbl[i].rdy_delay, tbl[i].ovr, tbl[i].lat);
        end
        load_frame(100, FRAME);
        wait_timeout();
        load_frame(100, FRAME);
        read_frame(3, 1'b0, 7);
        load_frame(100, 1000);
        iRESET         = 1'b1;
        bus.iADC_VALID = 1'b1;
        tick();
        ovr_exp = 1'b0;
        err_exp = 1'b0;
        chk_zero("midrst");
        iRESET         = 1'b0;
        bus.iADC_VALID = 1'b0;
        load_frame(100, FRAME);
        read_frame(0, 1'b0, 6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
